// File: rtl/aidan_mcnay_prime_ctrl_pkg.sv
// Shared widths and controller state encoding for the trial-division
// primality controller.
package aidan_mcnay_prime_ctrl_pkg;

    localparam int N_BITS_DEF  = 16;
    localparam int IN_BITS_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/aidan_mcnay_edge_detect_r.sv
// Rising-edge detector for level strobes. Both flops reset to 1 so a strobe
// already high when reset releases does not fire.
module aidan_mcnay_edge_detect_r (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic evt
);

    logic s1, s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= sig;
            s2 <= s1;
        end
    end

    assign evt = s1 & ~s2;

endmodule

// File: rtl/aidan_mcnay_prime_ctrl.sv
// Trial-division primality controller: byte-loaded candidate, divisors issued
// to an external remainder unit one at a time until d*d exceeds the candidate.
module aidan_mcnay_prime_ctrl
    import aidan_mcnay_prime_ctrl_pkg::*;
#(
    parameter int N_BITS  = N_BITS_DEF,
    parameter int IN_BITS = IN_BITS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [IN_BITS-1:0] in_data,
    input  logic               load_lo,
    input  logic               load_hi,
    input  logic               start,
    output logic               rem_req_val,
    input  logic               rem_req_rdy,
    output logic [N_BITS-1:0]  rem_dividend,
    output logic [N_BITS-1:0]  rem_divisor,
    input  logic               rem_resp_val,
    output logic               rem_resp_rdy,
    input  logic [N_BITS-1:0]  rem_resp_rem,
    output logic [N_BITS-1:0]  cand,
    output logic               busy,
    output logic               done,
    output logic               is_prime
);

    logic lo_evt, hi_evt, start_evt;

    aidan_mcnay_edge_detect_r u_ed_lo    (.clk(clk), .rst(reset), .sig(load_lo), .evt(lo_evt));
    aidan_mcnay_edge_detect_r u_ed_hi    (.clk(clk), .rst(reset), .sig(load_hi), .evt(hi_evt));
    aidan_mcnay_edge_detect_r u_ed_start (.clk(clk), .rst(reset), .sig(start),   .evt(start_evt));

    state_t            state;
    logic [N_BITS-1:0] d;
    logic [N_BITS:0]   sq;   // d*d, one bit wider so 256*256 fits

    // Loads are frozen outside IDLE/DONE, so cand doubles as the held dividend.
    assign rem_dividend = cand;
    assign rem_divisor  = d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cand         <= '0;
            d            <= '0;
            sq           <= '0;
            done         <= 1'b0;
            is_prime     <= 1'b0;
            busy         <= 1'b0;
            rem_req_val  <= 1'b0;
            rem_resp_rdy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (lo_evt) cand[IN_BITS-1:0]      <= in_data;
                    if (hi_evt) cand[N_BITS-1:IN_BITS] <= in_data;
                    if (start_evt) begin
                        d        <= N_BITS'(2);
                        sq       <= (N_BITS+1)'(4);
                        done     <= 1'b0;
                        is_prime <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cand < N_BITS'(2)) begin
                        done     <= 1'b1;
                        is_prime <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_DONE;
                    end else if (sq > {1'b0, cand}) begin
                        done     <= 1'b1;
                        is_prime <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_DONE;
                    end else begin
                        rem_req_val <= 1'b1;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (rem_req_rdy) begin
                        rem_req_val  <= 1'b0;
                        rem_resp_rdy <= 1'b1;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (rem_resp_val) begin
                        rem_resp_rdy <= 1'b0;
                        if (rem_resp_rem == '0) begin
                            done     <= 1'b1;
                            is_prime <= 1'b0;
                            busy     <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            // (d+1)^2 = d^2 + 2d + 1
                            d     <= d + N_BITS'(1);
                            sq    <= sq + {d, 1'b1};
                            state <= ST_CHECK;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
